// File: rtl/audio_pkg.sv
// Shared audio types and default dimensions for the I2S transmit path.
// Sample words are packed {left, right} with left in the upper half.
package audio_pkg;

    localparam int AUDIO_DATA_WIDTH  = 24;
    localparam int I2S_SLOT_WIDTH    = 32;
    localparam int I2S_BCLK_DIV_HALF = 4;
    localparam int AUDIO_FIFO_DEPTH  = 4;

    typedef struct packed {
        logic signed [AUDIO_DATA_WIDTH-1:0] left;
        logic signed [AUDIO_DATA_WIDTH-1:0] right;
    } stereo_sample_t;

    typedef enum logic [0:0] {
        CHAN_LEFT  = 1'b0,
        CHAN_RIGHT = 1'b1
    } i2s_chan_e;

endpackage

// File: rtl/audio_sample_fifo.sv
// Small synchronous FIFO of stereo sample words with first-word-fall-through head.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module audio_sample_fifo
    import audio_pkg::*;
#(
    parameter int WIDTH      = $bits(stereo_sample_t),
    parameter int FIFO_DEPTH = AUDIO_FIFO_DEPTH
) (
    input  logic                          i_clock,
    input  logic                          i_reset,
    input  logic                          push,
    input  logic [WIDTH-1:0]              push_data,
    input  logic                          pop,
    output logic [WIDTH-1:0]              head_data,
    output logic                          empty,
    output logic                          push_drop,
    output logic [$clog2(FIFO_DEPTH):0]   level
);

    localparam int AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    logic [WIDTH-1:0] mem_reg [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr_reg, wr_ptr_next;
    logic [AW-1:0]    rd_ptr_reg, rd_ptr_next;
    logic [LVL_W-1:0] level_reg, level_next;
    logic             full;
    logic             pop_ok;
    logic             push_ok;

    assign empty     = (level_reg == '0);
    assign full      = (level_reg == LVL_W'(FIFO_DEPTH));
    assign pop_ok    = pop && !empty;
    // When full, the head slot being popped is the one the push overwrites.
    assign push_ok   = push && (!full || pop_ok);
    assign push_drop = push && !push_ok;
    assign head_data = mem_reg[rd_ptr_reg];
    assign level     = level_reg;

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        level_next  = level_reg;
        if (push_ok) begin
            wr_ptr_next = wr_ptr_reg + AW'(1);
        end
        if (pop_ok) begin
            rd_ptr_next = rd_ptr_reg + AW'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   level_next = level_reg + LVL_W'(1);
            2'b01:   level_next = level_reg - LVL_W'(1);
            default: level_next = level_reg;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            level_reg  <= level_next;
        end
    end

    always_ff @(posedge i_clock) begin
        if (push_ok) begin
            mem_reg[wr_ptr_reg] <= push_data;
        end
    end

endmodule

// File: rtl/i2s_stereo_transmitter.sv
// Buffers stereo PCM samples and serialises them as standard I2S (one-BCLK MSB delay).
// All frame state advances on BCLK falling edges derived from a divided system clock.
module i2s_stereo_transmitter
    import audio_pkg::*;
#(
    parameter int DATA_WIDTH    = AUDIO_DATA_WIDTH,
    parameter int SLOT_WIDTH    = I2S_SLOT_WIDTH,
    parameter int BCLK_DIV_HALF = I2S_BCLK_DIV_HALF,
    parameter int FIFO_DEPTH    = AUDIO_FIFO_DEPTH
) (
    input  logic                          i_clock,
    input  logic                          i_reset,
    input  logic                          i_data_valid,
    input  logic [DATA_WIDTH-1:0]         i_data_left,
    input  logic [DATA_WIDTH-1:0]         i_data_right,
    output logic                          o_bclk,
    output logic                          o_lrclk,
    output logic                          o_sdata,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level,
    output logic                          o_overflow,
    output logic                          o_underflow
);

    localparam int FRAME_LEN = 2 * SLOT_WIDTH;
    localparam int F_W       = $clog2(FRAME_LEN);
    localparam int DIV_W     = (BCLK_DIV_HALF > 1) ? $clog2(BCLK_DIV_HALF) : 1;
    localparam int SW        = 2 * DATA_WIDTH;

    localparam logic [F_W-1:0]   SLOT_F   = F_W'(SLOT_WIDTH);
    localparam logic [F_W-1:0]   DATA_F   = F_W'(DATA_WIDTH);
    localparam logic [F_W-1:0]   LAST_F   = F_W'(FRAME_LEN - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV_HALF - 1);

    logic [DIV_W-1:0] div_cnt_reg, div_cnt_next;
    logic             bclk_reg, bclk_next;
    logic             lrclk_reg, lrclk_next;
    logic             sdata_reg, sdata_next;
    logic [F_W-1:0]   f_reg, f_next;
    logic [SW-1:0]    latched_reg, latched_next;
    logic             overflow_reg, overflow_next;
    logic             underflow_reg, underflow_next;

    logic             div_terminal;
    logic             fall_event;
    logic             frame_wrap;
    logic [SW-1:0]    fifo_head;
    logic             fifo_empty;
    logic             fifo_push_drop;

    i2s_chan_e        slot_chan;
    logic [F_W-1:0]   slot_pos;
    logic [DATA_WIDTH-1:0] chan_word;
    logic [DATA_WIDTH-1:0] chan_shifted;
    logic             sdata_bit;

    assign div_terminal = (div_cnt_reg == DIV_LAST);
    assign fall_event   = div_terminal && bclk_reg;
    assign frame_wrap   = fall_event && (f_reg == LAST_F);

    audio_sample_fifo #(
        .WIDTH      (SW),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clock   (i_clock),
        .i_reset   (i_reset),
        .push      (i_data_valid),
        .push_data ({i_data_left, i_data_right}),
        .pop       (frame_wrap),
        .head_data (fifo_head),
        .empty     (fifo_empty),
        .push_drop (fifo_push_drop),
        .level     (o_fifo_level)
    );

    // The bit driven for index f+1 belongs to the slot position of the current index f.
    always_comb begin
        slot_chan = (f_reg >= SLOT_F) ? CHAN_RIGHT : CHAN_LEFT;
        slot_pos  = (slot_chan == CHAN_RIGHT) ? (f_reg - SLOT_F) : f_reg;
        chan_word = (slot_chan == CHAN_RIGHT) ? latched_reg[DATA_WIDTH-1:0]
                                              : latched_reg[SW-1:DATA_WIDTH];
        chan_shifted = chan_word << slot_pos;
        sdata_bit    = (slot_pos < DATA_F) ? chan_shifted[DATA_WIDTH-1] : 1'b0;
    end

    always_comb begin
        div_cnt_next   = div_cnt_reg + DIV_W'(1);
        bclk_next      = bclk_reg;
        f_next         = f_reg;
        lrclk_next     = lrclk_reg;
        sdata_next     = sdata_reg;
        latched_next   = latched_reg;
        overflow_next  = overflow_reg | fifo_push_drop;
        underflow_next = underflow_reg;

        if (div_terminal) begin
            div_cnt_next = '0;
            bclk_next    = !bclk_reg;
        end

        if (fall_event) begin
            f_next     = frame_wrap ? '0 : (f_reg + F_W'(1));
            lrclk_next = (f_next >= SLOT_F);
            sdata_next = sdata_bit;
            if (frame_wrap) begin
                if (fifo_empty) begin
                    latched_next   = '0;
                    underflow_next = 1'b1;
                end else begin
                    latched_next = fifo_head;
                end
            end
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            div_cnt_reg   <= '0;
            bclk_reg      <= 1'b0;
            f_reg         <= '0;
            lrclk_reg     <= 1'b0;
            sdata_reg     <= 1'b0;
            latched_reg   <= '0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            div_cnt_reg   <= div_cnt_next;
            bclk_reg      <= bclk_next;
            f_reg         <= f_next;
            lrclk_reg     <= lrclk_next;
            sdata_reg     <= sdata_next;
            latched_reg   <= latched_next;
            overflow_reg  <= overflow_next;
            underflow_reg <= underflow_next;
        end
    end

    assign o_bclk      = bclk_reg;
    assign o_lrclk     = lrclk_reg;
    assign o_sdata     = sdata_reg;
    assign o_overflow  = overflow_reg;
    assign o_underflow = underflow_reg;

endmodule
